mem_resp_router: RTL

- Return-path counterpart of the memory request arbiter.
- Snoops each issued memory request (id, instruction/data source, write flag) into a per-id tracking table.
- When memory returns a response tagged with that id, routes it back to the instruction side or data side with registered, single-cycle outputs.
- Sits between the memory response port and the I/D cache fill interfaces. Also flags protocol errors.

---
 rtl/mem_resp_router_if.sv | 37 +++
 rtl/mem_resp_router.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_resp_router_if.sv
// Bundle of the request-snoop, memory-response and I/D fill signals for mem_resp_router.
// The master modport drives requests and responses. The slave modport is the router side.
interface mem_resp_router_if #(
    parameter int LINE_BYTES = 64,
    parameter int ID_WIDTH   = 4
);
    logic                    i_req_enable;
    logic [ID_WIDTH-1:0]     i_req_id;
    logic                    i_req_is_data;
    logic                    i_req_write;
    logic                    i_mem_valid;
    logic [ID_WIDTH-1:0]     i_mem_id;
    logic [LINE_BYTES*8-1:0] i_mem_data;
    logic                    o_instr_valid;
    logic [LINE_BYTES*8-1:0] o_instr_data;
    logic                    o_data_valid;
    logic [LINE_BYTES*8-1:0] o_data_rdata;
    logic                    o_data_wack;
    logic [ID_WIDTH:0]       o_outstanding;
    logic                    o_full;
    logic                    o_err;
    logic                    o_timeout;

    modport master (
        output i_req_enable, i_req_id, i_req_is_data, i_req_write,
        output i_mem_valid, i_mem_id, i_mem_data,
        input  o_instr_valid, o_instr_data, o_data_valid, o_data_rdata,
        input  o_data_wack, o_outstanding, o_full, o_err, o_timeout
    );

    modport slave (
        input  i_req_enable, i_req_id, i_req_is_data, i_req_write,
        input  i_mem_valid, i_mem_id, i_mem_data,
        output o_instr_valid, o_instr_data, o_data_valid, o_data_rdata,
        output o_data_wack, o_outstanding, o_full, o_err, o_timeout
    );
endinterface

// File: rtl/mem_resp_router.sv
// Routes tagged memory responses to the I or D fill port, using a per-id table of snooped requests.
// Defining RESP_TIMEOUT_EN adds a sticky watchdog for responses that never arrive.
module mem_resp_router #(
    parameter int LINE_BYTES     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_resp_router_if.slave   bus
);
    localparam int NUM_IDS = 2**ID_WIDTH;
    localparam int DW      = LINE_BYTES*8;
    localparam logic [ID_WIDTH:0] FULL_CNT = (ID_WIDTH+1)'(NUM_IDS);

    logic [NUM_IDS-1:0] r_valid;
    logic [NUM_IDS-1:0] r_is_data;
    logic [NUM_IDS-1:0] r_is_write;
    logic [ID_WIDTH:0]  r_cnt;
    logic               r_instr_valid;
    logic               r_data_valid;
    logic               r_data_wack;
    logic               r_err;
    logic [DW-1:0]      r_instr_data;
    logic [DW-1:0]      r_data_rdata;

    logic               w_hit;
    logic               w_unknown;
    logic               w_same;
    logic               w_overwrite;
    logic               w_alloc_new;
    logic               w_hit_data;
    logic               w_hit_write;
    logic [ID_WIDTH+1:0] w_cnt_sum;
    logic [ID_WIDTH:0]  w_cnt_next;

    assign w_hit       = bus.i_mem_valid & r_valid[bus.i_mem_id];
    assign w_unknown   = bus.i_mem_valid & ~r_valid[bus.i_mem_id];
    assign w_hit_data  = r_is_data[bus.i_mem_id];
    assign w_hit_write = r_is_write[bus.i_mem_id];
    // A retire and re-allocate on the same id is a legal hand-over, not an overwrite.
    assign w_same      = w_hit & bus.i_req_enable & (bus.i_req_id == bus.i_mem_id);
    assign w_overwrite = bus.i_req_enable & r_valid[bus.i_req_id] & ~w_same;
    assign w_alloc_new = bus.i_req_enable & ~w_overwrite;

    assign w_cnt_sum  = {1'b0, r_cnt} + (ID_WIDTH+2)'(w_alloc_new) - (ID_WIDTH+2)'(w_hit);
    assign w_cnt_next = (w_cnt_sum > {1'b0, FULL_CNT}) ? FULL_CNT : w_cnt_sum[ID_WIDTH:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_is_data  <= '0;
            r_is_write <= '0;
        end else begin
            for (int k = 0; k < NUM_IDS; k++) begin
                if (w_hit && bus.i_mem_id == ID_WIDTH'(k)) begin
                    r_valid[k] <= 1'b0;
                end
                if (bus.i_req_enable && bus.i_req_id == ID_WIDTH'(k)) begin
                    r_valid[k]    <= 1'b1;
                    r_is_data[k]  <= bus.i_req_is_data;
                    r_is_write[k] <= bus.i_req_write;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_instr_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            r_data_wack   <= 1'b0;
            r_err         <= 1'b0;
            r_instr_data  <= '0;
            r_data_rdata  <= '0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_instr_valid <= w_hit & ~w_hit_data;
            r_data_valid  <= w_hit & w_hit_data & ~w_hit_write;
            r_data_wack   <= w_hit & w_hit_data & w_hit_write;
            if (w_unknown || w_overwrite) begin
                r_err <= 1'b1;
            end
            if (w_hit && !w_hit_data) begin
                r_instr_data <= bus.i_mem_data;
            end
            if (w_hit && w_hit_data && !w_hit_write) begin
                r_data_rdata <= bus.i_mem_data;
            end
        end
    end

    assign bus.o_instr_valid = r_instr_valid;
    assign bus.o_instr_data  = r_instr_data;
    assign bus.o_data_valid  = r_data_valid;
    assign bus.o_data_rdata  = r_data_rdata;
    assign bus.o_data_wack   = r_data_wack;
    assign bus.o_outstanding = r_cnt;
    assign bus.o_full        = (r_cnt == FULL_CNT);
    assign bus.o_err         = r_err;

`ifdef RESP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] r_wd;
    logic            r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_hit || r_cnt == '0) begin
                r_wd <= '0;
            end else if (r_wd != WD_LIMIT) begin
                r_wd <= r_wd + 1'b1;
            end
            if (r_wd == WD_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.o_timeout = r_timeout;
`else
    assign bus.o_timeout = 1'b0;
`endif
endmodule
